// File: rtl/hdmi_line_fetcher.sv
// Writes the 32-bit pixel-word stream into the HDMI output stage's ping-pong line RAM,
// paced by the resynchronised vertical-valid flag and current display line.
module hdmi_line_fetcher #(
  parameter int unsigned WORDS_PER_LINE = 960,
  parameter int unsigned LINES          = 1080,
  parameter int unsigned IDX_W          = 10
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        v_valid_in,
  input  logic [11:0] locy_in,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        wea,
  output logic [31:0] addra,
  output logic [31:0] dina,
  output logic        frame_req,
  output logic        underrun
);

  typedef enum logic [1:0] {StIdle, StFill, StWaitLine, StDone} state_e;

  state_e state_q, state_d;

  logic             vv_meta_q, vv_s_q, vv_prev_q;
  logic [11:0]      ly_meta_q, ly_s_q, ly_prev_q, ly_stab_q;
  logic [10:0]      line_q, line_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wea_q, wea_d;
  logic [31:0]      addra_q, addra_d;
  logic [31:0]      dina_q, dina_d;
  logic             frame_req_q, frame_req_d;
  logic             underrun_q, underrun_d;

  logic        vv_fall;
  logic [12:0] ly_ext, line_ext;
  logic        disp_at_line, disp_before_line, underrun_hit, last_word, last_line;

  // Synchronisers; ly_stab only follows ly_s once it has held for two samples so a
  // multi-bit transition caught mid-flight is never used.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      vv_meta_q <= 1'b0;
      vv_s_q    <= 1'b0;
      vv_prev_q <= 1'b0;
      ly_meta_q <= '0;
      ly_s_q    <= '0;
      ly_prev_q <= '0;
      ly_stab_q <= '0;
    end else begin
      vv_meta_q <= v_valid_in;
      vv_s_q    <= vv_meta_q;
      vv_prev_q <= vv_s_q;
      ly_meta_q <= locy_in;
      ly_s_q    <= ly_meta_q;
      ly_prev_q <= ly_s_q;
      if (ly_s_q == ly_prev_q) ly_stab_q <= ly_s_q;
    end
  end

  assign vv_fall  = vv_prev_q & ~vv_s_q;
  assign ly_ext   = {1'b0, ly_stab_q};
  assign line_ext = {2'b00, line_q};

  // Display is on or past line L: bank L[0] is being scanned (underrun), or line L+1 may start.
  assign disp_at_line     = vv_s_q && (ly_ext >= line_ext);
  // Display is on or past line L-1: bank L[0] is free for line L.
  assign disp_before_line = vv_s_q && ((ly_ext + 13'd1) >= line_ext);
  assign underrun_hit     = ((state_q == StFill) || (state_q == StWaitLine)) &&
                            (line_q != '0) && disp_at_line;
  assign last_word        = (idx_q == IDX_W'(WORDS_PER_LINE - 1));
  assign last_line        = ((line_q + 11'd1) == 11'(LINES));

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    idx_d       = idx_q;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    frame_req_d = 1'b0;
    underrun_d  = underrun_q;

    if (vv_fall) begin
      // New frame wins over everything, including a same-cycle transfer.
      frame_req_d = 1'b1;
      line_d      = '0;
      idx_d       = '0;
      state_d     = StFill;
      underrun_d  = (state_q == StFill) || (state_q == StWaitLine);
    end else begin
      if (underrun_hit) underrun_d = 1'b1;
      case (state_q)
        StFill: begin
          if (s_valid) begin
            wea_d   = 1'b1;
            addra_d = {{(32 - IDX_W - 1){1'b0}}, line_q[0], idx_q};
            dina_d  = s_data;
            if (last_word) begin
              idx_d  = '0;
              line_d = line_q + 11'd1;
              if (last_line)         state_d = StDone;
              else if (!disp_at_line) state_d = StWaitLine;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StWaitLine: begin
          if (disp_before_line) state_d = StFill;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q     <= StIdle;
      line_q      <= '0;
      idx_q       <= '0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      frame_req_q <= frame_req_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_ready   = (state_q == StFill);
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign frame_req = frame_req_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Directed bench for hdmi_line_fetcher with a 4-word, 3-line frame.
module tb_hdmi_line_fetcher;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        v_valid_in;
  logic [11:0] locy_in;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic        frame_req;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  typedef struct {
    logic        sv;
    logic [31:0] data;
    logic        wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        rdy;
    logic        freq;
  } vec_t;

  vec_t tbl[6];

  hdmi_line_fetcher #(
    .WORDS_PER_LINE(4),
    .LINES         (3),
    .IDX_W         (2)
  ) dut (
    .clk_100   (clk_100),
    .reset     (reset),
    .v_valid_in(v_valid_in),
    .locy_in   (locy_in),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .frame_req (frame_req),
    .underrun  (underrun)
  );

  always #5 clk_100 = ~clk_100;

  // Write log, sampled just after the active edge.
  always @(posedge clk_100) begin
    #1;
    if (wea) begin
      wq_a.push_back(addra);
      wq_d.push_back(dina);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_100);
  endtask

  task automatic feed(input logic [31:0] base, input int n, input bit toggle);
    int got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      s_valid = !toggle || (c % 2 == 0);
      s_data  = base + 32'(got);
      if (s_valid && s_ready) got++;
      @(negedge clk_100);
    end
    s_valid = 1'b0;
    chk("feed_done", 32'(got), 32'(n));
  endtask

  task automatic wait_freq(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_100);
      if (frame_req) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_sready(input string name);
    for (int i = 0; i < 20 && !s_ready; i++) @(negedge clk_100);
    chk(name, 32'(s_ready), 32'd1);
  endtask

  task automatic check_writes(input string name, input int base_n, input logic [31:0] a0,
                              input logic [31:0] d0, input int n);
    chk({name, "_count"}, 32'(wq_a.size() - base_n), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base_n + i < wq_a.size()) begin
        chk($sformatf("%s_addr%0d", name, i), wq_a[base_n + i], a0 + 32'(i));
        chk($sformatf("%s_data%0d", name, i), wq_d[base_n + i], d0 + 32'(i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nw;
    bit seen_freq, seen_wea, seen_rdy;

    // Line 0 fill, one row per cycle, starting at the cycle frame_req is seen.
    tbl[0] = '{1'b1, 32'hA0, 1'b1, 32'd0, 32'hA0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'hA1, 1'b1, 32'd1, 32'hA1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'hA2, 1'b1, 32'd2, 32'hA2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'hA3, 1'b1, 32'd3, 32'hA3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 32'd3, 32'hA3, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'hA5, 1'b0, 32'd3, 32'hA3, 1'b0, 1'b0};

    reset      = 1'b1;
    v_valid_in = 1'b1;
    locy_in    = 12'd0;
    s_valid    = 1'b0;
    s_data     = 32'h0;
    step(3);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", addra, 32'd0);
    chk("rst_dina", dina, 32'd0);
    chk("rst_freq", 32'(frame_req), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);

    // IDLE must not start mid-frame.
    reset     = 1'b0;
    s_valid   = 1'b1;
    s_data    = 32'h55;
    seen_freq = 0;
    seen_wea  = 0;
    seen_rdy  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_100);
      seen_freq |= frame_req;
      seen_wea  |= wea;
      seen_rdy  |= s_ready;
    end
    chk("idle_freq", 32'(seen_freq), 32'd0);
    chk("idle_wea", 32'(seen_wea), 32'd0);
    chk("idle_sready", 32'(seen_rdy), 32'd0);

    // Frame start: frame_req three cycles after the fall.
    s_valid    = 1'b0;
    v_valid_in = 1'b0;
    wait_freq(lat);
    chk("freq_latency", 32'(lat), 32'd3);
    chk("freq_underrun", 32'(underrun), 32'd0);
    for (int r = 0; r < 6; r++) begin
      s_valid = tbl[r].sv;
      s_data  = tbl[r].data;
      @(negedge clk_100);
      chk($sformatf("tbl%0d_wea", r), 32'(wea), 32'(tbl[r].wea));
      chk($sformatf("tbl%0d_addra", r), addra, tbl[r].addra);
      chk($sformatf("tbl%0d_dina", r), dina, tbl[r].dina);
      chk($sformatf("tbl%0d_sready", r), 32'(s_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_freq", r), 32'(frame_req), 32'(tbl[r].freq));
    end

    // Line 1 with gappy s_valid goes to bank 1.
    v_valid_in = 1'b1;
    nw = wq_a.size();
    feed(32'hB0, 4, 1'b1);
    step(2);
    check_writes("line1", nw, 32'd4, 32'hB0, 4);
    chk("line1_waitline", 32'(s_ready), 32'd0);
    chk("line1_underrun", 32'(underrun), 32'd0);

    // Line 2 once display reaches line 1, then DONE.
    locy_in = 12'd1;
    nw = wq_a.size();
    feed(32'hC0, 4, 1'b0);
    step(2);
    check_writes("line2", nw, 32'd0, 32'hC0, 4);
    chk("done_sready", 32'(s_ready), 32'd0);
    chk("done_underrun", 32'(underrun), 32'd0);

    // Frame A: starve line 1 until the display catches up.
    v_valid_in = 1'b0;
    locy_in    = 12'd0;
    wait_freq(lat);
    chk("fa_freq_seen", 32'(lat != 0), 32'd1);
    chk("fa_underrun0", 32'(underrun), 32'd0);
    feed(32'hD0, 4, 1'b0);
    step(2);
    v_valid_in = 1'b1;
    wait_sready("fa_line1_ready");
    chk("fa_pre_underrun", 32'(underrun), 32'd0);
    locy_in = 12'd1;
    for (int i = 0; i < 20 && !underrun; i++) @(negedge clk_100);
    chk("fa_underrun_set", 32'(underrun), 32'd1);
    chk("fa_still_filling", 32'(s_ready), 32'd1);
    nw = wq_a.size();
    feed(32'hE0, 4, 1'b0);
    check_writes("fa_line1", nw, 32'd4, 32'hE0, 4);
    chk("fa_back_to_back", 32'(s_ready), 32'd1);
    feed(32'hF0, 4, 1'b0);
    step(2);
    chk("fa_sticky", 32'(underrun), 32'd1);

    // Clean frame start clears the flag.
    v_valid_in = 1'b0;
    locy_in    = 12'd0;
    wait_freq(lat);
    chk("fb_freq_seen", 32'(lat != 0), 32'd1);
    chk("fb_underrun_clr", 32'(underrun), 32'd0);

    // Frame B: fall while waiting for line 2.
    feed(32'h10, 4, 1'b0);
    step(2);
    v_valid_in = 1'b1;
    wait_sready("fb_line1_ready");
    feed(32'h20, 4, 1'b0);
    step(2);
    chk("fb_waitline", 32'(s_ready), 32'd0);
    chk("fb_underrun0", 32'(underrun), 32'd0);
    nw = wq_a.size();
    s_valid    = 1'b1;
    s_data     = 32'h30;
    v_valid_in = 1'b0;
    wait_freq(lat);
    chk("fb_freq_seen", 32'(lat != 0), 32'd1);
    chk("fb_underrun_set", 32'(underrun), 32'd1);
    feed(32'h30, 1, 1'b0);
    step(2);
    check_writes("fb_restart", nw, 32'd0, 32'h30, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
